// File: rtl/pi_serial_frontend.sv
// -----------------------------------------------------------------------------
// pi_serial_frontend
//   Receive-side front end of the Pi-to-CPLD serial link. The Pi's raw GPIO
//   strobes are synchronised into clk. Rising edges of the serial clock become
//   single-cycle SHIFT commands and rising edges of the latch strobe become
//   single-cycle LATCH commands. Both are addressed to one of NUM_REGS 8-bit
//   serial-in/parallel-out registers. Bits are counted per frame, and short,
//   long and mis-addressed frames raise a sticky error flag.
//
//   Optional build macro: PI_SERIAL_DEGLITCH_EN
//     If defined, the synced sclk/sle must hold a new level for 2 clk cycles
//     before the edge is accepted. Latency becomes SYNC_STAGES+3, and
//     sdata/rsel are delayed to match. If undefined, latency is SYNC_STAGES+1.
//
// Ports
//   clk        in   system clock, all logic on posedge
//   rst        in   synchronous active-high reset
//   pi_sclk    in   raw serial clock (asynchronous)
//   pi_sdata   in   raw serial data (asynchronous, stable around sclk rise)
//   pi_sle     in   raw latch request (asynchronous)
//   pi_rsel    in   raw target register select, stable for the whole frame
//   sr_cs      out  one-hot command strobe to the shift registers
//   sr_le      out  1 = latch command, 0 = shift command (valid with sr_cs)
//   sr_din     out  serial bit for a shift command
//   frame_done out  one-cycle pulse: clean latch after exactly FRAME_BITS shifts
//   frame_err  out  sticky error flag
//   err_clr    in   clears frame_err (an error in the same cycle wins)
//   bit_cnt    out  shifts in the current frame, saturating at 15
// -----------------------------------------------------------------------------
module pi_serial_frontend #(
   parameter int SYNC_STAGES = 2,
   parameter int FRAME_BITS  = 8,
   parameter int NUM_REGS    = 4,
   localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                pi_sclk,
   input  logic                pi_sdata,
   input  logic                pi_sle,
   input  logic [RW-1:0]       pi_rsel,
   output logic [NUM_REGS-1:0] sr_cs,
   output logic                sr_le,
   output logic                sr_din,
   output logic                frame_done,
   output logic                frame_err,
   input  logic                err_clr,
   output logic [3:0]          bit_cnt
);

   typedef enum logic [1:0] {IDLE, SHIFTING, LATCH} state_t;

   // ---------------- input synchronisers ----------------
   logic [SYNC_STAGES-1:0]         sclk_sync_q, sdata_sync_q, sle_sync_q;
   logic [SYNC_STAGES-1:0][RW-1:0] rsel_sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_sync_q  <= '0;
         sdata_sync_q <= '0;
         sle_sync_q   <= '0;
         rsel_sync_q  <= '0;
      end else begin
         sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], pi_sclk};
         sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], pi_sdata};
         sle_sync_q   <= {sle_sync_q[SYNC_STAGES-2:0], pi_sle};
         rsel_sync_q  <= {rsel_sync_q[SYNC_STAGES-2:0], pi_rsel};
      end
   end

   logic          sclk_s, sdata_s, sle_s;
   logic [RW-1:0] rsel_s;
   assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
   assign sdata_s = sdata_sync_q[SYNC_STAGES-1];
   assign sle_s   = sle_sync_q[SYNC_STAGES-1];
   assign rsel_s  = rsel_sync_q[SYNC_STAGES-1];

   // Levels fed to the edge detectors and the data/select aligned with them.
   logic          sclk_lvl, sle_lvl, sdata_al;
   logic [RW-1:0] rsel_al;

`ifdef PI_SERIAL_DEGLITCH_EN
   // A level is accepted only once the synced input has shown it on two
   // consecutive cycles. The filtered level therefore trails the synced input
   // by two cycles, and sdata/rsel are pushed through two flops to stay aligned.
   logic                sclk_h_q, sle_h_q, sclk_f_q, sle_f_q;
   logic [1:0]          sdata_dly_q;
   logic [1:0][RW-1:0]  rsel_dly_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_h_q    <= 1'b0;
         sle_h_q     <= 1'b0;
         sclk_f_q    <= 1'b0;
         sle_f_q     <= 1'b0;
         sdata_dly_q <= '0;
         rsel_dly_q  <= '0;
      end else begin
         sclk_h_q <= sclk_s;
         sle_h_q  <= sle_s;
         if (sclk_s == sclk_h_q) sclk_f_q <= sclk_s;
         if (sle_s == sle_h_q)   sle_f_q  <= sle_s;
         sdata_dly_q <= {sdata_dly_q[0], sdata_s};
         rsel_dly_q  <= {rsel_dly_q[0], rsel_s};
      end
   end

   assign sclk_lvl = sclk_f_q;
   assign sle_lvl  = sle_f_q;
   assign sdata_al = sdata_dly_q[1];
   assign rsel_al  = rsel_dly_q[1];
`else
   assign sclk_lvl = sclk_s;
   assign sle_lvl  = sle_s;
   assign sdata_al = sdata_s;
   assign rsel_al  = rsel_s;
`endif

   // ---------------- edge detection ----------------
   logic sclk_prev_q, sle_prev_q;
   logic sclk_rise, sle_rise;

   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_prev_q <= 1'b0;
         sle_prev_q  <= 1'b0;
      end else begin
         sclk_prev_q <= sclk_lvl;
         sle_prev_q  <= sle_lvl;
      end
   end

   assign sclk_rise = sclk_lvl & ~sclk_prev_q;
   assign sle_rise  = sle_lvl & ~sle_prev_q;

   // ---------------- command FSM ----------------
   function automatic logic [NUM_REGS-1:0] onehot(input logic [RW-1:0] s);
      logic [NUM_REGS-1:0] v;
      v = '0;
      for (int i = 0; i < NUM_REGS; i++)
         if (int'(s) == i) v[i] = 1'b1;
      return v;
   endfunction

   state_t              state_q, state_d;
   logic [RW-1:0]       frame_sel_q, frame_sel_d;
   logic                frame_bad_q, frame_bad_d;   // an error has hit the frame since the last latch
   logic [3:0]          bit_cnt_q, bit_cnt_d;
   logic [NUM_REGS-1:0] sr_cs_q, sr_cs_d;
   logic                sr_le_q, sr_le_d, sr_din_q, sr_din_d;
   logic                frame_done_q, frame_done_d, frame_err_q, frame_err_d;
   logic                err_set;
   logic [RW-1:0]       sel;

   always_comb begin
      state_d      = state_q;
      frame_sel_d  = frame_sel_q;
      frame_bad_d  = frame_bad_q;
      bit_cnt_d    = bit_cnt_q;
      sr_cs_d      = '0;
      sr_le_d      = 1'b0;
      sr_din_d     = 1'b0;
      frame_done_d = 1'b0;
      err_set      = 1'b0;
      sel          = rsel_al;

      if (sle_rise) begin
         // Latch wins over a coincident shift. The shift is dropped and flagged.
         if (state_q == SHIFTING) sel = frame_sel_q;
         sr_cs_d = onehot(sel);
         sr_le_d = 1'b1;
         if (sclk_rise || frame_bad_q || bit_cnt_q != 4'(FRAME_BITS) || int'(sel) >= NUM_REGS)
            err_set = 1'b1;
         else
            frame_done_d = 1'b1;
         bit_cnt_d   = 4'd0;
         frame_bad_d = 1'b0;
         state_d     = (state_q == SHIFTING) ? LATCH : IDLE;
      end else if (sclk_rise) begin
         if (state_q == SHIFTING && rsel_al == frame_sel_q) begin
            sel       = frame_sel_q;
            bit_cnt_d = (bit_cnt_q == 4'd15) ? bit_cnt_q : bit_cnt_q + 4'd1;
         end else begin
            // First shift of a frame, or a select change mid-frame that restarts it.
            sel         = rsel_al;
            frame_sel_d = rsel_al;
            bit_cnt_d   = 4'd1;
            state_d     = SHIFTING;
            if (state_q == SHIFTING) begin
               err_set     = 1'b1;
               frame_bad_d = 1'b1;
            end
         end
         if (int'(sel) >= NUM_REGS) begin
            err_set     = 1'b1;
            frame_bad_d = 1'b1;
         end
         sr_cs_d  = onehot(sel);
         sr_din_d = sdata_al;
      end else if (state_q == LATCH) begin
         state_d = IDLE;
      end

      frame_err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : frame_err_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         frame_sel_q  <= '0;
         frame_bad_q  <= 1'b0;
         bit_cnt_q    <= 4'd0;
         sr_cs_q      <= '0;
         sr_le_q      <= 1'b0;
         sr_din_q     <= 1'b0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         frame_sel_q  <= frame_sel_d;
         frame_bad_q  <= frame_bad_d;
         bit_cnt_q    <= bit_cnt_d;
         sr_cs_q      <= sr_cs_d;
         sr_le_q      <= sr_le_d;
         sr_din_q     <= sr_din_d;
         frame_done_q <= frame_done_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign sr_cs      = sr_cs_q;
   assign sr_le      = sr_le_q;
   assign sr_din     = sr_din_q;
   assign frame_done = frame_done_q;
   assign frame_err  = frame_err_q;
   assign bit_cnt    = bit_cnt_q;

endmodule

// File: tb/tb_pi_serial_frontend.sv
// -----------------------------------------------------------------------------
// tb_pi_serial_frontend
//   Directed bench for pi_serial_frontend using the default parameters
//   (SYNC_STAGES=2, FRAME_BITS=8, NUM_REGS=4). Pins are driven on the falling
//   edge of clk and outputs are sampled on the falling edge. A raw rising edge
//   therefore appears as a command LAT falling edges later.
// -----------------------------------------------------------------------------
module tb_pi_serial_frontend;

`ifdef PI_SERIAL_DEGLITCH_EN
   localparam int LAT = 5;
`else
   localparam int LAT = 3;
`endif

   logic       clk = 1'b0;
   logic       rst, pi_sclk, pi_sdata, pi_sle, err_clr;
   logic [1:0] pi_rsel;
   logic [3:0] sr_cs;
   logic       sr_le, sr_din, frame_done, frame_err;
   logic [3:0] bit_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pi_serial_frontend dut (
      .clk        (clk),
      .rst        (rst),
      .pi_sclk    (pi_sclk),
      .pi_sdata   (pi_sdata),
      .pi_sle     (pi_sle),
      .pi_rsel    (pi_rsel),
      .sr_cs      (sr_cs),
      .sr_le      (sr_le),
      .sr_din     (sr_din),
      .frame_done (frame_done),
      .frame_err  (frame_err),
      .err_clr    (err_clr),
      .bit_cnt    (bit_cnt)
   );

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One sclk pulse. The command must be absent one cycle early, present for
   // exactly one cycle at LAT, and carry the expected target, data and count.
   task automatic do_shift(input logic b, input logic [3:0] exp_cs,
                           input logic [3:0] exp_cnt, input string tag);
      pi_sdata = b;
      pi_sclk  = 1'b1;
      tick(LAT - 1);
      chk({tag, "_early"}, 32'(sr_cs), 32'h0);
      tick(1);
      chk({tag, "_cs"},  32'(sr_cs),   32'(exp_cs));
      chk({tag, "_le"},  32'(sr_le),   32'h0);
      chk({tag, "_din"}, 32'(sr_din),  32'(b));
      chk({tag, "_cnt"}, 32'(bit_cnt), 32'(exp_cnt));
      pi_sclk = 1'b0;
      tick(1);
      chk({tag, "_once"}, 32'(sr_cs), 32'h0);
      tick(2);
   endtask

   // Shifts nbits of v, MSB first. The count starts at start_cnt and saturates at 15.
   task automatic shift_bits(input logic [7:0] v, input int nbits, input logic [3:0] exp_cs,
                             input int start_cnt, input string tag);
      for (int i = 0; i < nbits; i++) begin
         int c;
         c = start_cnt + i + 1;
         if (c > 15) c = 15;
         do_shift(v[7 - i], exp_cs, 4'(c), $sformatf("%s_b%0d", tag, i));
      end
   endtask

   task automatic do_latch(input logic [3:0] exp_cs, input logic chk_done, input logic exp_done,
                           input logic exp_err, input string tag);
      pi_sle = 1'b1;
      tick(LAT - 1);
      chk({tag, "_early"}, 32'(sr_cs), 32'h0);
      tick(1);
      chk({tag, "_cs"},  32'(sr_cs),     32'(exp_cs));
      chk({tag, "_le"},  32'(sr_le),     32'h1);
      chk({tag, "_err"}, 32'(frame_err), 32'(exp_err));
      chk({tag, "_cnt"}, 32'(bit_cnt),   32'h0);
      if (chk_done) chk({tag, "_done"}, 32'(frame_done), 32'(exp_done));
      pi_sle = 1'b0;
      tick(1);
      chk({tag, "_once"},     32'(sr_cs),      32'h0);
      chk({tag, "_donepls"},  32'(frame_done), 32'h0);
      tick(2);
   endtask

   task automatic clear_err(input string tag);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      chk({tag, "_clr"}, 32'(frame_err), 32'h0);
   endtask

   task automatic set_rsel(input logic [1:0] r);
      pi_rsel = r;
      tick(LAT + 1);
   endtask

   initial begin
      rst = 1'b1; pi_sclk = 1'b0; pi_sdata = 1'b0; pi_sle = 1'b0; pi_rsel = 2'd0; err_clr = 1'b0;

      // 1. reset held 3 cycles
      tick(3);
      rst = 1'b0;
      tick(1);
      chk("rst_cs",   32'(sr_cs),      32'h0);
      chk("rst_le",   32'(sr_le),      32'h0);
      chk("rst_din",  32'(sr_din),     32'h0);
      chk("rst_done", 32'(frame_done), 32'h0);
      chk("rst_err",  32'(frame_err),  32'h0);
      chk("rst_cnt",  32'(bit_cnt),    32'h0);

      // 2. good frame 8'hA5 to register 2
      set_rsel(2'd2);
      shift_bits(8'hA5, 8, 4'b0100, 0, "t2");
      do_latch(4'b0100, 1'b1, 1'b1, 1'b0, "t2_latch");

      // 3. short frame of 7 bits to register 0, then err_clr
      set_rsel(2'd0);
      shift_bits(8'h5A, 7, 4'b0001, 0, "t3");
      do_latch(4'b0001, 1'b1, 1'b0, 1'b1, "t3_latch");
      clear_err("t3");

      // 4. 8 shifts, then sclk and sle rise together. Only the latch is issued.
      //    err_clr is asserted in the same cycle the error is raised.
      shift_bits(8'hC3, 8, 4'b0001, 0, "t4");
      pi_sdata = 1'b1;
      pi_sclk  = 1'b1;
      pi_sle   = 1'b1;
      tick(LAT - 1);
      err_clr = 1'b1;
      tick(1);
      chk("t4_cs",   32'(sr_cs),      32'h1);
      chk("t4_le",   32'(sr_le),      32'h1);
      chk("t4_err",  32'(frame_err),  32'h1);
      chk("t4_done", 32'(frame_done), 32'h0);
      chk("t4_cnt",  32'(bit_cnt),    32'h0);
      pi_sclk = 1'b0;
      pi_sle  = 1'b0;
      tick(1);
      chk("t4_noshift", 32'(sr_cs),     32'h0);
      chk("t4_clr",     32'(frame_err), 32'h0);
      err_clr = 1'b0;
      tick(2);

      // 5. rsel changes 1 -> 3 after 4 shifts, then 8 more shifts and a latch
      set_rsel(2'd1);
      shift_bits(8'hF0, 4, 4'b0010, 0, "t5a");
      chk("t5_noerr", 32'(frame_err), 32'h0);
      set_rsel(2'd3);
      do_shift(1'b1, 4'b1000, 4'd1, "t5_chg");
      chk("t5_err", 32'(frame_err), 32'h1);
      shift_bits(8'h35, 7, 4'b1000, 1, "t5b");
      do_latch(4'b1000, 1'b0, 1'b0, 1'b1, "t5_latch");

      // 6. 16 shifts: count saturates at 15 and the latch flags a long frame
      clear_err("t6");
      set_rsel(2'd2);
      shift_bits(8'h96, 8, 4'b0100, 0, "t6a");
      shift_bits(8'h69, 8, 4'b0100, 8, "t6b");
      do_latch(4'b0100, 1'b1, 1'b0, 1'b1, "t6_latch");

      // 7. a following good frame still pulses frame_done, and frame_err stays sticky
      set_rsel(2'd1);
      shift_bits(8'h3C, 8, 4'b0010, 0, "t7");
      do_latch(4'b0010, 1'b1, 1'b1, 1'b1, "t7_latch");

      // 8. reset mid-frame discards the partial frame
      shift_bits(8'hE0, 3, 4'b0010, 0, "t8a");
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(1);
      chk("t8_cnt", 32'(bit_cnt),   32'h0);
      chk("t8_err", 32'(frame_err), 32'h0);
      shift_bits(8'h81, 8, 4'b0010, 0, "t8b");
      do_latch(4'b0010, 1'b1, 1'b1, 1'b0, "t8_latch");

`ifdef PI_SERIAL_DEGLITCH_EN
      // 9. a 1-cycle sclk glitch is ignored, and a 3-cycle pulse gives one command at LAT
      pi_sdata = 1'b1;
      pi_sclk  = 1'b1;
      tick(1);
      pi_sclk = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         chk($sformatf("t9_glitch%0d", i), 32'(sr_cs), 32'h0);
      end
      chk("t9_glitch_cnt", 32'(bit_cnt), 32'h0);
      pi_sclk = 1'b1;
      tick(3);
      pi_sclk = 1'b0;
      tick(1);
      chk("t9_early", 32'(sr_cs), 32'h0);
      tick(1);
      chk("t9_cs",  32'(sr_cs),  32'h2);
      chk("t9_din", 32'(sr_din), 32'h1);
      tick(1);
      chk("t9_once", 32'(sr_cs), 32'h0);
      tick(4);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
